// File: rtl/switch_output_queue.sv
// Egress output-queue stage: one circular FIFO per port, fed one tagged word per cycle
// from the fabric, drained per port through the port_out/port_ready/port_read handshake.
module switch_output_queue #(
  parameter int unsigned N_PORTS      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 12,
  parameter bit          DROP_ON_FULL = 1'b0,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned PORT_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int unsigned LVL_W       = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [PORT_W-1:0]          in_port,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic [N_PORTS*DATA_W-1:0]  port_out,
  output logic [N_PORTS-1:0]         port_ready,
  input  logic [N_PORTS-1:0]         port_read,
  output logic [N_PORTS*LVL_W-1:0]   port_level,
  output logic [N_PORTS-1:0]         almost_full,
  output logic [N_PORTS*CNT_W-1:0]   drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem    [N_PORTS][DEPTH];
  logic [AW-1:0]     rd_ptr [N_PORTS];
  logic [AW-1:0]     wr_ptr [N_PORTS];
  logic [LVL_W-1:0]  level  [N_PORTS];
  logic [CNT_W-1:0]  drops  [N_PORTS];

  logic [N_PORTS-1:0] hit, full, wr_en, drop_en, rd_en;
  logic               sel_full;

  // Port decode and transfer qualification, judged on start-of-cycle levels only.
  always_comb begin
    hit      = '0;
    full     = '0;
    wr_en    = '0;
    drop_en  = '0;
    rd_en    = '0;
    sel_full = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      full[p] = (level[p] == LVL_W'(DEPTH));
      hit[p]  = (in_port == PORT_W'(p));
      if (hit[p]) sel_full = full[p];
    end
    // Unknown port indices are always accepted and silently discarded.
    in_ready = !(|hit) || DROP_ON_FULL || !sel_full;
    for (int p = 0; p < N_PORTS; p++) begin
      wr_en[p]   = in_valid && hit[p] && !full[p];
      drop_en[p] = in_valid && hit[p] && full[p] && DROP_ON_FULL;
      rd_en[p]   = port_read[p] && (level[p] != '0);
    end
  end

  // Pointers, levels and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < N_PORTS; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        level[p]  <= '0;
        drops[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (wr_en[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
        if (rd_en[p]) rd_ptr[p] <= rd_ptr[p] + AW'(1);
        if (wr_en[p] && !rd_en[p])      level[p] <= level[p] + LVL_W'(1);
        else if (!wr_en[p] && rd_en[p]) level[p] <= level[p] - LVL_W'(1);
        if (drop_en[p] && (drops[p] != '1)) drops[p] <= drops[p] + CNT_W'(1);
      end
    end
  end

  // Storage is intentionally not reset; the levels gate visibility.
  always_ff @(posedge clk) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (wr_en[p]) mem[p][wr_ptr[p]] <= in_data;
    end
  end

  always_comb begin
    port_out    = '0;
    port_ready  = '0;
    port_level  = '0;
    almost_full = '0;
    drop_cnt    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      port_ready[p]                    = (level[p] != '0);
      almost_full[p]                   = (level[p] >= LVL_W'(AFULL_THRESH));
      port_level[p*LVL_W +: LVL_W]     = level[p];
      drop_cnt[p*CNT_W +: CNT_W]       = drops[p];
      if (port_ready[p])
        port_out[p*DATA_W +: DATA_W]   = mem[p][rd_ptr[p]];
    end
  end

endmodule
